// File: rtl/audio_playback_sequencer.sv
// -----------------------------------------------------------------------------
// audio_playback_sequencer
//
// Sequences the audio playback datapath. A play pulse latches an inclusive
// address range; the block then fetches one sample at a time from sample
// memory over a req/ack handshake and presents each fetched sample once per
// sample period (CLK_DIV clocks). The output stage sees a one-cycle strobe.
//
// Parameters:
//   ADDR_W   sample memory address width
//   DATA_W   sample width
//   CLK_DIV  clk cycles per sample period
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ena                 tick enable (freezes only the tick counter)
//   play, stop          start / stop pulses (stop wins when both are high)
//   loop_en             restart at start_addr after end_addr
//   start_addr/end_addr inclusive playback range, latched on play
//   mem_req/mem_addr    read request toward sample memory
//   mem_ack/mem_data    read response, mem_ack qualifies mem_data
//   sample/current_addr presented sample and its address
//   sample_stb          one-cycle pulse in the cycle that commits a new sample;
//                       sample/current_addr carry it from the next cycle on
//   busy                high in any state except IDLE
//   done                one-cycle pulse after the last sample of a non-loop run
//
// Optional feature (macro UNDERRUN_CNT_EN):
//   defined   -> adds underrun_cnt[7:0], counts ticks that land in REQ,
//                saturating at 255, cleared on accepted play and on rst
//   undefined -> no port, no counter
// -----------------------------------------------------------------------------
module audio_playback_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_stb,
  output logic [ADDR_W-1:0] current_addr,
  output logic              busy,
  output logic              done
`ifdef UNDERRUN_CNT_EN
  ,
  output logic [7:0]        underrun_cnt
`endif
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [ADDR_W-1:0]   start_q,    start_d;
  logic [ADDR_W-1:0]   end_q,      end_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic                pend_q,     pend_d;
  logic [DATA_W-1:0]   buf_q,      buf_d;
  logic [DATA_W-1:0]   sample_q,   sample_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic                done_q,     done_d;
`ifdef UNDERRUN_CNT_EN
  logic [7:0]          ucnt_q,     ucnt_d;
`endif

  logic busy_w;
  logic tick;
  logic play_ok;
  logic stb;

  assign busy_w  = (state_q != S_IDLE);
  assign tick    = busy_w && ena && (cnt_q == CNT_LAST);
  // An empty/reversed range and a play that collides with stop are dropped.
  assign play_ok = play && !stop && (state_q == S_IDLE) && (end_addr >= start_addr);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d    = state_q;
    addr_d     = addr_q;
    start_d    = start_q;
    end_d      = end_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    buf_d      = buf_q;
    sample_d   = sample_q;
    cur_addr_d = cur_addr_q;
    done_d     = 1'b0;
    stb        = 1'b0;
`ifdef UNDERRUN_CNT_EN
    ucnt_d     = ucnt_q;
`endif

    // Sample-period counter: restarts on play, frozen by ena or in IDLE.
    if (play_ok) begin
      cnt_d = '0;
    end else if (busy_w && ena) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (play_ok) begin
          start_d = start_addr;
          end_d   = end_addr;
          addr_d  = start_addr;
          pend_d  = 1'b0;
          state_d = S_REQ;
`ifdef UNDERRUN_CNT_EN
          ucnt_d  = 8'd0;
`endif
        end
      end

      S_REQ: begin
        // Tick before the fetch completes: remember one, present it late.
        if (tick) begin
          pend_d = 1'b1;
`ifdef UNDERRUN_CNT_EN
          if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
`endif
        end
        if (mem_ack) begin
          buf_d   = mem_data;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        // A coincident tick and pending flag still yield a single strobe.
        if (tick || pend_q) begin
          stb        = 1'b1;
          sample_d   = buf_q;
          cur_addr_d = addr_q;
          pend_d     = 1'b0;
          if (addr_q != end_q) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_REQ;
          end else if (loop_en) begin
            addr_d  = start_q;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // stop overrides everything above: abandon the fetch, keep the last
    // presented sample, and report no completion.
    if (stop) begin
      state_d    = S_IDLE;
      pend_d     = 1'b0;
      sample_d   = sample_q;
      cur_addr_d = cur_addr_q;
      done_d     = 1'b0;
      stb        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before this edge, independent of order.
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      start_q    <= '0;
      end_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      buf_q      <= '0;
      sample_q   <= '0;
      cur_addr_q <= '0;
      done_q     <= 1'b0;
`ifdef UNDERRUN_CNT_EN
      ucnt_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      start_q    <= start_d;
      end_q      <= end_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      buf_q      <= buf_d;
      sample_q   <= sample_d;
      cur_addr_q <= cur_addr_d;
      done_q     <= done_d;
`ifdef UNDERRUN_CNT_EN
      ucnt_q     <= ucnt_d;
`endif
    end
  end

  assign mem_req      = (state_q == S_REQ);
  assign mem_addr     = addr_q;
  assign sample       = sample_q;
  assign sample_stb   = stb;
  assign current_addr = cur_addr_q;
  assign busy         = busy_w;
  assign done         = done_q;
`ifdef UNDERRUN_CNT_EN
  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: doc/audio_playback_sequencer.md
Name: audio_playback_sequencer

Overview:
Controller that sequences the audio player datapath. It accepts play/stop commands over an address range and generates sample-rate ticks from the system clock. It fetches samples from sample memory over a req/ack handshake and presents each sample to the 1-bit audio output stage with a strobe. It sits between the top-level control pins and the sample ROM/PWM path.

Parameters:
ADDR_W, 10, sample memory address width
DATA_W, 8, sample width
CLK_DIV, 50, clk cycles per sample period (400 kHz / 50 = 8 kHz)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ena  input  1  tick enable; low freezes tick counter only
play  input  1  start pulse
stop  input  1  stop pulse
loop_en  input  1  restart at start_addr after end_addr
start_addr  input  ADDR_W  first sample address
end_addr  input  ADDR_W  last sample address, inclusive
mem_req  output  1  memory read request
mem_addr  output  ADDR_W  memory read address
mem_ack  input  1  read data valid, qualifies mem_data
mem_data  input  DATA_W  read data
sample  output  DATA_W  current audio sample
sample_stb  output  1  1-cycle pulse when sample updates
current_addr  output  ADDR_W  address of the sample on sample
busy  output  1  high in any state except IDLE
done  output  1  1-cycle pulse at non-loop end of range

Behaviour:
- Reset: all outputs 0. State IDLE. Tick counter 0. Pending-tick flag 0.
- States: IDLE, REQ, HOLD.
- IDLE: play with end_addr >= start_addr latches both addresses, sets addr = start, clears the tick counter and pending tick, and enters REQ next cycle. play with end_addr < start_addr is ignored (no done).
- REQ: mem_req = 1 and mem_addr = addr. Both stay stable until mem_ack. On the mem_ack cycle, mem_data is latched into the prefetch buffer, mem_req drops next cycle, and the state goes to HOLD.
- Tick counter: runs when busy and ena. Counts 0..CLK_DIV-1 and asserts tick when the count = CLK_DIV-1, then wraps to 0. First tick comes CLK_DIV cycles after the play cycle (ena high).
- Tick in REQ: is an underrun. Sets the pending-tick flag; only one is remembered.
- HOLD, on tick or pending flag: sample <= buffer, current_addr <= addr, sample_stb = 1 for one cycle, pending flag cleared. Then:
  - addr != end: addr + 1, go to REQ.
  - addr == end and loop_en: addr = start, go to REQ. loop_en is sampled on this cycle.
  - addr == end and !loop_en: go to IDLE, done = 1 for one cycle.
- Pending tick on ack: the strobe fires on the cycle after ack. Pending ticks add no extra strobes.
- stop: accepted in any state. Next cycle: IDLE, mem_req = 0, no done. sample and current_addr hold. An ack arriving after stop is ignored.
- stop and play in the same cycle: stop wins and play is dropped.
- play while busy: ignored.
- Address arithmetic is modulo 2^ADDR_W. Wrap cannot occur because end >= start.
- rst mid-operation: returns to the reset values next edge regardless of handshake state.

Optional Feature:
UNDERRUN_CNT_EN
- Defined: adds output underrun_cnt [7:0]. It increments on every tick in REQ, saturates at 255, clears on accepted play and on rst.
- Undefined: no port and no counter. Underrun handling is otherwise identical.

Test Plan:
- CLK_DIV=4, ack 1 cycle after req, start=0x010, end=0x012, loop_en=0, play -> 3 strobes spaced 4 cycles, first at play+4. current_addr 0x010, 0x011, 0x012. done 1 cycle after the last strobe; busy low after.
- Same range, loop_en=1, run 7 ticks -> current_addr sequence 0x010, 0x011, 0x012, 0x010, 0x011, 0x012, 0x010. No done.
- CLK_DIV=4, ack delayed 6 cycles -> tick during REQ; strobe on cycle after ack. Next strobe not doubled. With UNDERRUN_CNT_EN, underrun_cnt = 1.
- stop while mem_req high, then late mem_ack -> mem_req 0 next cycle; sample unchanged; no strobe, no done; busy 0.
- play with start=0x020, end=0x01F -> stays IDLE, mem_req never asserted. Same-cycle play+stop from IDLE -> stays IDLE.
- ena low for 10 cycles mid-HOLD -> strobe delayed by exactly 10 cycles. Assert rst in REQ -> all outputs 0 next cycle.
